// File: rtl/matmul_partition_udiv_step.sv
// Purpose: one restoring-division iteration (shift in one dividend bit, compare, conditionally subtract).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencing divider decides when the result is registered.
//
// Ports:
//   rem_in  - current partial remainder (always < divisor for a nonzero divisor)
//   bit_in  - next dividend bit, taken MSB first
//   divisor - captured divisor
//   rem_out - partial remainder after this iteration
//   q_bit   - quotient bit produced by this iteration
module matmul_partition_udiv_step #(
  parameter int M = 63
) (
  input  logic [M-1:0] rem_in,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_out,
  output logic         q_bit
);

  // The shifted remainder needs M+1 bits: it can reach 2*divisor-1.
  logic [M:0]   partial;
  logic [M-1:0] diff;

  assign partial = {rem_in, bit_in};

  // When the subtract succeeds the true difference is below the divisor,
  // so M bits of modular subtraction hold it exactly. With a zero divisor
  // this keeps the low M bits of the shifted value, which is what makes the
  // remainder come out as the low bits of the dividend.
  assign diff    = partial[M-1:0] - divisor;
  assign q_bit   = (partial >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : partial[M-1:0];

endmodule

// File: rtl/matmul_partition_udiv_94ns_63ns_seq.sv
// Purpose: sequential unsigned divider, N-bit dividend / M-bit divisor, one quotient bit per enabled edge.
// Latency: done rises N+1 ce-enabled edges after the accepting edge (N iterations + one commit edge).
// Backpressure: ready low while busy; start is ignored then; ce=0 freezes all state and outputs.
//
// Ports:
//   clk, reset (sync, active low), ce (clock enable), start, din0 (dividend), din1 (divisor)
//   ready (start will be accepted), done (one-cycle result strobe), quot, rem, div0 (divisor was zero)
module matmul_partition_udiv_94ns_63ns_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 94,
  parameter int din1_WIDTH = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div0
);

  localparam int N     = din0_WIDTH;
  localparam int M     = din1_WIDTH;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  // Dividend shifts out MSB first while quotient bits shift in at the LSB,
  // so after N iterations this register holds the quotient.
  logic [N-1:0]   dvd;
  logic [M-1:0]   part;
  logic [M-1:0]   dsr;

  logic [M-1:0]   step_rem;
  logic           step_q;

  matmul_partition_udiv_step #(
    .M (M)
  ) u_step (
    .rem_in  (part),
    .bit_in  (dvd[N-1]),
    .divisor (dsr),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      part  <= '0;
      dsr   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      div0  <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd   <= din0;
            dsr   <= din1;
            part  <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= S_RUN;
          end else begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt == LAST) begin
            // All N bits consumed: publish the result on this edge.
            quot  <= dvd;
            rem   <= part;
            div0  <= (dsr == '0);
            done  <= 1'b1;
            ready <= 1'b1;
            state <= S_DONE;
          end else begin
            dvd  <= {dvd[N-2:0], step_q};
            part <= step_rem;
            cnt  <= cnt + 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
